// File: rtl/cdc_fifo_read_ctrl.sv
// cdc_fifo_read_ctrl: read-domain pointer and flag controller for a dual-clock FIFO.
// - Synchronises the Gray write pointer into the read clock domain.
// - Owns the binary read pointer and a registered Gray copy for the write domain.
// - Derives empty, almost_empty and fill level from the synchronised write pointer.
// Optional feature: define CDC_FIFO_READ_UNDERFLOW_EN to build the sticky underflow
// flag and its simulation assertion. When undefined, underflow is tied to 0.
module cdc_fifo_read_ctrl #(
    parameter int ADDRESS_WIDTH          = 4,
    parameter int SYNC_STAGES            = 2,
    parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     increment,
    input  logic [ADDRESS_WIDTH:0]   write_pointer_gray,
    output logic [ADDRESS_WIDTH-1:0] read_address,
    output logic [ADDRESS_WIDTH:0]   read_pointer_gray,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [ADDRESS_WIDTH:0]   level,
    output logic                     underflow
);

    localparam int PW = ADDRESS_WIDTH + 1;
    localparam logic [ADDRESS_WIDTH:0] AE_THRESHOLD = PW'(ALMOST_EMPTY_THRESHOLD);

    logic [ADDRESS_WIDTH:0] sync_q [SYNC_STAGES];
    logic [ADDRESS_WIDTH:0] write_pointer_bin;
    logic [ADDRESS_WIDTH:0] read_pointer;
    logic [ADDRESS_WIDTH:0] read_pointer_next;
    logic                   pop;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [ADDRESS_WIDTH:0] gray_to_bin(input logic [ADDRESS_WIDTH:0] g);
        logic [ADDRESS_WIDTH:0] b;
        b[ADDRESS_WIDTH] = g[ADDRESS_WIDTH];
        for (int i = ADDRESS_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

    // Plain flop chain on the Gray write pointer; nothing may sit between stages.
    // NOTE: the synchroniser stages are cleared by reset like any other flop so the
    // read side never decodes a stale write pointer after reset; the write side is
    // reset in the same event, so 0 is the correct post-reset value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample the previous
            // stage's old value, which is what turns the loop into a shift chain.
            sync_q[0] <= write_pointer_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i - 1];
            end
        end
    end

    // Decode the last synchroniser stage and derive level and flags from flops only.
    // NOTE: every signal gets an unconditional assignment here, so no latch can form.
    always_comb begin
        write_pointer_bin = gray_to_bin(sync_q[SYNC_STAGES - 1]);
        level             = write_pointer_bin - read_pointer;
        empty             = (level == '0);
        almost_empty      = (level <= AE_THRESHOLD);
        pop               = increment && !empty;
        read_pointer_next = read_pointer + PW'(pop);
        read_address      = read_pointer[ADDRESS_WIDTH-1:0];
    end

    // Read pointer and its Gray copy update together, so the Gray output is a flop
    // that changes at most one bit per pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_pointer      <= '0;
            read_pointer_gray <= '0;
        end else begin
            read_pointer      <= read_pointer_next;
            read_pointer_gray <= read_pointer_next ^ (read_pointer_next >> 1);
        end
    end

`ifdef CDC_FIFO_READ_UNDERFLOW_EN
    // Sticky underflow: set by any pop request while empty, held until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            underflow <= 1'b0;
        end else if (increment && empty) begin
            underflow <= 1'b1;
        end
    end

    underflow_check : assert property (@(posedge clock) disable iff (reset) !(increment && empty));
`else
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_fifo_read_ctrl.sv
// tb_cdc_fifo_read_ctrl: scoreboard bench for cdc_fifo_read_ctrl with default parameters.
// A behavioural model computes expected outputs per clock edge, pushes them to a queue,
// and the entry is popped and compared against the DUT one time unit after the edge.
module tb_cdc_fifo_read_ctrl;

    localparam int AW  = 4;
    localparam int SS  = 2;
    localparam int AET = 1;
    localparam int PW  = AW + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          increment = 1'b0;
    logic [AW:0]   write_pointer_gray = '0;
    logic [AW-1:0] read_address;
    logic [AW:0]   read_pointer_gray;
    logic          empty;
    logic          almost_empty;
    logic [AW:0]   level;
    logic          underflow;

    cdc_fifo_read_ctrl #(
        .ADDRESS_WIDTH(AW),
        .SYNC_STAGES(SS),
        .ALMOST_EMPTY_THRESHOLD(AET)
    ) dut (
        .clock(clock),
        .reset(reset),
        .increment(increment),
        .write_pointer_gray(write_pointer_gray),
        .read_address(read_address),
        .read_pointer_gray(read_pointer_gray),
        .empty(empty),
        .almost_empty(almost_empty),
        .level(level),
        .underflow(underflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW:0]   gray;
        logic [AW:0]   lvl;
        logic          emp;
        logic          aemp;
        logic          uf;
        logic          pop;
    } expect_t;

    expect_t     scoreboard[$];
    logic [AW:0] hist[$];
    logic [AW:0] m_rp   = '0;
    logic [AW:0] m_vis  = '0;
    logic [AW:0] wr_bin = '0;
    logic        m_uf   = 1'b0;
    int          checks = 0;
    int          passed = 0;

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, compare after it.
    task automatic step(input logic inc, input logic [AW:0] wb);
        expect_t     e;
        logic [AW:0] gray_before;
        increment          = inc;
        wr_bin             = wb;
        write_pointer_gray = bin2gray(wb);
        gray_before        = read_pointer_gray;
        @(posedge clock);
        e.pop = inc && (m_vis != m_rp);
`ifdef CDC_FIFO_READ_UNDERFLOW_EN
        if (inc && (m_vis == m_rp)) m_uf = 1'b1;
`endif
        hist.push_back(wb);
        if (hist.size() > SS) void'(hist.pop_front());
        m_rp   = m_rp + PW'(e.pop);
        m_vis  = (hist.size() == SS) ? hist[0] : '0;
        e.addr = m_rp[AW-1:0];
        e.gray = bin2gray(m_rp);
        e.lvl  = m_vis - m_rp;
        e.emp  = (e.lvl == '0);
        e.aemp = (e.lvl <= PW'(AET));
        e.uf   = m_uf;
        scoreboard.push_back(e);
        #1;
        e = scoreboard.pop_front();
        check("read_address", 32'(read_address), 32'(e.addr));
        check("read_pointer_gray", 32'(read_pointer_gray), 32'(e.gray));
        check("level", 32'(level), 32'(e.lvl));
        check("empty", 32'(empty), 32'(e.emp));
        check("almost_empty", 32'(almost_empty), 32'(e.aemp));
        check("underflow", 32'(underflow), 32'(e.uf));
        check("gray_bits_changed", 32'($countones(gray_before ^ read_pointer_gray)), 32'(e.pop));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_read_address"}, 32'(read_address), 32'd0);
        check({tag, "_read_pointer_gray"}, 32'(read_pointer_gray), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_almost_empty"}, 32'(almost_empty), 32'd1);
        check({tag, "_underflow"}, 32'(underflow), 32'd0);
    endtask

    // Asynchronous reset between edges; write side resets in the same event.
    task automatic apply_reset(input string tag);
        #2;
        reset              = 1'b1;
        increment          = 1'b0;
        wr_bin             = '0;
        write_pointer_gray = '0;
        #1;
        check_reset_values(tag);
        hist.delete();
        m_rp  = '0;
        m_vis = '0;
        m_uf  = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [AW:0] nb;
        logic        inc;

        // Reset state.
        #2;
        check_reset_values("por");
        @(negedge clock);
        reset = 1'b0;

        // Write pointer steps bin 0 -> 1 -> 2; level appears SS edges later.
        step(1'b0, 5'd0);
        step(1'b0, 5'd1);
        step(1'b0, 5'd1);
        step(1'b0, 5'd2);
        step(1'b0, 5'd2);
        step(1'b0, 5'd2);

        // Full depth visible without being reported empty.
        for (int i = 0; i < 4; i++) step(1'b0, 5'd16);
        check("full_level", 32'(level), 32'd16);
        check("full_not_empty", 32'(empty), 32'd0);

        // Drain all 16 entries, then pop once more while empty.
        for (int i = 0; i < 16; i++) step(1'b1, 5'd16);
        check("drained_empty", 32'(empty), 32'd1);
        step(1'b1, 5'd16);
        step(1'b0, 5'd16);
        step(1'b0, 5'd16);

        // Random streaming of writes and pops across the pointer wrap.
        for (int i = 0; i < 80; i++) begin
            inc = ($urandom_range(0, 3) != 0);
            nb  = wr_bin;
            if (($urandom_range(0, 3) != 0) && (PW'(wr_bin - m_rp) < PW'(16))) nb = wr_bin + 1'b1;
            step(inc, nb);
        end
        for (int i = 0; i < 20; i++) step(1'b1, wr_bin);

        // Build level 5 and reset mid-stream.
        nb = m_rp + 5'd5;
        for (int i = 0; i < 3; i++) step(1'b0, nb);
        check("pre_reset_level", 32'(level), 32'd5);
        apply_reset("mid");

        // Normal operation resumes after reset.
        step(1'b0, 5'd1);
        step(1'b0, 5'd1);
        step(1'b1, 5'd1);
        step(1'b0, 5'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
